// File: rtl/nonce_miner_if.sv
// Hasher-side bus of the nonce search controller: message/control out, hash/finished back.
interface nonce_miner_if;
   logic [7:0] hash_msg;
   logic       hash_rst_n;
   logic       hash_en;
   logic [7:0] hash_in;
   logic       hash_done;

   modport master (output hash_msg, hash_rst_n, hash_en, input hash_in, hash_done);
   modport slave  (input hash_msg, hash_rst_n, hash_en, output hash_in, hash_done);
endinterface

// File: rtl/nonce_miner.sv
// Nonce search controller: one reset/enable/capture trial per nonce against an external
// 8-bit hasher, stopping at the first hash strictly below the latched target.
module nonce_miner #(
   parameter int NONCE_W  = 8,
   parameter int MAX_WAIT = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [7:0]         block_data,
   input  logic [7:0]         target,
   nonce_miner_if.master      hif,
   output logic               busy,
   output logic               found,
   output logic               exhausted,
   output logic               timeout,
   output logic [NONCE_W-1:0] nonce,
   output logic [7:0]         hash_out
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [2:0] state;
   logic [7:0] block_q, target_q, hash_q, wait_cnt;
   logic [7:0] msg_q;
   logic       rst_n_q, en_q;

   // Upper nonce bits fold into the byte; the shift yields zero when NONCE_W is 8.
   function automatic logic [7:0] msg_of(input logic [7:0] b, input logic [NONCE_W-1:0] n);
      return b ^ n[7:0] ^ 8'(n >> 8);
   endfunction

   assign hif.hash_msg   = msg_q;
   assign hif.hash_rst_n = rst_n_q;
   assign hif.hash_en    = en_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         block_q   <= '0;
         target_q  <= '0;
         hash_q    <= '0;
         wait_cnt  <= '0;
         msg_q     <= '0;
         rst_n_q   <= 1'b1;
         en_q      <= 1'b0;
         busy      <= 1'b0;
         found     <= 1'b0;
         exhausted <= 1'b0;
         timeout   <= 1'b0;
         nonce     <= '0;
         hash_out  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  block_q   <= block_data;
                  target_q  <= target;
                  nonce     <= '0;
                  msg_q     <= block_data;
                  rst_n_q   <= 1'b0;
                  en_q      <= 1'b0;
                  busy      <= 1'b1;
                  found     <= 1'b0;
                  exhausted <= 1'b0;
                  timeout   <= 1'b0;
                  hash_out  <= '0;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               rst_n_q  <= 1'b1;
               en_q     <= 1'b1;
               wait_cnt <= '0;
               state    <= RUN;
            end
            RUN: begin
               // A finish in the last allowed cycle still wins over the timeout.
               if (hif.hash_done) begin
                  hash_q <= hif.hash_in;
                  en_q   <= 1'b0;
                  state  <= CHECK;
               end else if (wait_cnt == WAIT_LAST) begin
                  en_q    <= 1'b0;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            CHECK: begin
               if (hash_q < target_q) begin
                  found    <= 1'b1;
                  hash_out <= hash_q;
                  busy     <= 1'b0;
                  state    <= DONE;
               end else if (&nonce) begin
                  exhausted <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  nonce   <= nonce + 1'b1;
                  msg_q   <= msg_of(block_q, nonce + 1'b1);
                  rst_n_q <= 1'b0;
                  state   <= CLEAR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nonce_miner.sv
// Bench for nonce_miner: stub hasher (hash = msg ^ key, finish at a chosen RUN cycle),
// fixed vectors, hand sequences for restart/reset corners, and random searches vs a model.
module tb_nonce_miner;
   localparam int NONCE_W  = 8;
   localparam int MAX_WAIT = 16;
   localparam int LIMIT    = 5000;

   typedef struct {
      logic [7:0] blk;
      logic [7:0] tgt;
      int         r;
      logic [7:0] key;
      logic       f, e, t;
      logic [7:0] n;
      logic [7:0] h;
      int         cyc;
      int         hen;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [7:0] block_data = '0, target = '0;
   logic busy, found, exhausted, timeout;
   logic [NONCE_W-1:0] nonce;
   logic [7:0] hash_out;

   nonce_miner_if hif ();

   nonce_miner #(.NONCE_W(NONCE_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .block_data(block_data), .target(target),
      .hif(hif), .busy(busy), .found(found), .exhausted(exhausted), .timeout(timeout),
      .nonce(nonce), .hash_out(hash_out)
   );

   always #5 clock = ~clock;

   int         stub_r = 3;
   logic [7:0] stub_key = 8'h5A;
   logic [7:0] run_cyc = '0;

   always @(posedge clock) begin
      if (!hif.hash_rst_n) run_cyc <= 8'd1;
      else if (hif.hash_en) run_cyc <= run_cyc + 8'd1;
   end

   assign hif.hash_in   = hif.hash_msg ^ stub_key;
   assign hif.hash_done = hif.hash_en && (stub_r != 0) && (int'(run_cyc) == stub_r);

   int vectors = 0, errors = 0;
   int cyc, hen;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [7:0] blk, input logic [7:0] tgt, input int r,
                                  input logic [7:0] key);
      vec_t m;
      m.blk = blk; m.tgt = tgt; m.r = r; m.key = key;
      m.f = 0; m.e = 0; m.t = 0; m.n = 0; m.h = 0;
      if (r == 0 || r > MAX_WAIT) begin
         m.t = 1; m.cyc = MAX_WAIT + 2; m.hen = MAX_WAIT;
         return m;
      end
      for (int n = 0; n < 256; n++) begin
         logic [7:0] hv;
         hv = blk ^ 8'(n) ^ key;
         if (hv < tgt) begin
            m.f = 1; m.n = 8'(n); m.h = hv;
            m.cyc = n * (r + 2) + r + 3; m.hen = (n + 1) * r;
            return m;
         end
      end
      m.e = 1; m.n = 8'hFF; m.cyc = 256 * (r + 2) + 1; m.hen = 256 * r;
      return m;
   endfunction

   task automatic run_search(input logic [7:0] blk, input logic [7:0] tgt, input int r,
                             input logic [7:0] key, input int disturb);
      stub_r = r; stub_key = key;
      @(negedge clock);
      block_data = blk; target = tgt; start = 1'b1;
      @(negedge clock);
      start = 1'b0; cyc = 1; hen = 0;
      chk("clear_busy", int'(busy), 1);
      chk("clear_hash_rst_n", int'(hif.hash_rst_n), 0);
      chk("clear_flags", int'({found, exhausted, timeout}), 0);
      while (!(found | exhausted | timeout) && cyc < LIMIT) begin
         if (hif.hash_en) hen++;
         if (cyc == disturb) begin
            start = 1'b1; target = ~tgt; block_data = ~blk;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      if (cyc >= LIMIT) chk("search_watchdog", cyc, 0);
   endtask

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_found"}, int'(found), int'(v.f));
      chk({tag, "_exhausted"}, int'(exhausted), int'(v.e));
      chk({tag, "_timeout"}, int'(timeout), int'(v.t));
      chk({tag, "_nonce"}, int'(nonce), int'(v.n));
      chk({tag, "_hash_out"}, int'(hash_out), int'(v.h));
      chk({tag, "_cycles"}, cyc, v.cyc);
      chk({tag, "_hash_en_cycles"}, hen, v.hen);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_flags"}, int'({found, exhausted, timeout}), 0);
      chk({tag, "_hash_en"}, int'(hif.hash_en), 0);
      chk({tag, "_hash_rst_n"}, int'(hif.hash_rst_n), 1);
      chk({tag, "_nonce"}, int'(nonce), 0);
      chk({tag, "_hash_msg"}, int'(hif.hash_msg), 0);
      chk({tag, "_hash_out"}, int'(hash_out), 0);
   endtask

   vec_t tbl[4];

   initial begin
      //          blk    tgt    R  key    f  e  t  nonce  hash   cyc   hen
      tbl[0] = '{8'h00, 8'h10, 3, 8'h5A, 1, 0, 0, 8'h50, 8'h0A, 406,  243};
      tbl[1] = '{8'h00, 8'h00, 3, 8'h5A, 0, 1, 0, 8'hFF, 8'h00, 1281, 768};
      tbl[2] = '{8'h00, 8'h10, 0, 8'h5A, 0, 0, 1, 8'h00, 8'h00, 18,   16};
      tbl[3] = '{8'hA5, 8'h01, 1, 8'h5A, 1, 0, 0, 8'hFF, 8'h00, 769,  256};

      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         run_search(tbl[i].blk, tbl[i].tgt, tbl[i].r, tbl[i].key, 0);
         check_result($sformatf("vec%0d", i), tbl[i]);
      end

      // start and input changes mid-search must be ignored; a start in DONE reruns cleanly
      run_search(8'h00, 8'h10, 3, 8'h5A, 50);
      check_result("disturb", tbl[0]);
      run_search(8'h00, 8'h10, 3, 8'h5A, 0);
      check_result("rerun", tbl[0]);

      // reset in the middle of the RUN phase of nonce 0x20
      stub_r = 3; stub_key = 8'h5A;
      @(negedge clock);
      block_data = 8'h00; target = 8'h10; start = 1'b1;
      @(negedge clock);
      start = 1'b0; cyc = 0;
      while (!(nonce == 8'h20 && hif.hash_en) && cyc < LIMIT) begin
         @(negedge clock);
         cyc++;
      end
      if (cyc >= LIMIT) chk("midrun_watchdog", cyc, 0);
      reset_n = 1'b0;
      @(negedge clock);
      check_reset_outputs("midrun_reset");
      reset_n = 1'b1;
      run_search(8'h00, 8'h10, 3, 8'h5A, 0);
      check_result("after_reset", tbl[0]);

      for (int i = 0; i < 12; i++) begin
         logic [7:0] b, t, k;
         int r;
         vec_t m;
         b = 8'($urandom); t = 8'($urandom); k = 8'($urandom);
         r = $urandom_range(0, 5);
         if (i == 11) r = MAX_WAIT + 1;
         m = model(b, t, r, k);
         run_search(b, t, r, k, (i % 3 == 0) ? 7 : 0);
         check_result($sformatf("rand%0d", i), m);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
